// File: rtl/panic_hash_dispatch_pkg.sv
// ============================================================================
// panic_hash_dispatch_pkg : state type for the packet dispatch FSM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef PANIC_DEFINE_SV
`include "panic_define.sv"
`endif

package panic_hash_dispatch_pkg;

   typedef enum logic [1:0] {
      ST_DESC    = `PANIC_ST_DESC,
      ST_PAYLOAD = `PANIC_ST_PAYLOAD,
      ST_PAD     = `PANIC_ST_PAD
   } state_t;

endpackage
`default_nettype wire

// File: rtl/panic_define.sv
// ============================================================================
// panic_define : shared macros for the panic hash dispatch block
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef PANIC_DEFINE_SV
`define PANIC_DEFINE_SV

`define PANIC_DESC_WIDTH 128

`define PANIC_ST_DESC    2'd0
`define PANIC_ST_PAYLOAD 2'd1
`define PANIC_ST_PAD     2'd2

`define PANIC_LANE_W(n) (((n) > 1) ? $clog2(n) : 1)

`endif
`default_nettype wire

// File: rtl/panic_sync_fifo.sv
// ============================================================================
// panic_sync_fifo : synchronous first-word-fall-through FIFO, async reset
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module panic_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push, pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = push ? bump(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? bump(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule
`default_nettype wire

// File: rtl/panic_hash_dispatch.sv
// ============================================================================
// panic_hash_dispatch : spreads packets round-robin over hash lanes and
//                       returns digests in packet order
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef PANIC_DEFINE_SV
`include "panic_define.sv"
`endif

module panic_hash_dispatch
   import panic_hash_dispatch_pkg::*;
#(
   parameter int DATA_WIDTH   = 512,
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter int DESC_WIDTH   = `PANIC_DESC_WIDTH,
   parameter int LANES        = 2,
   parameter int RES_WIDTH    = 512,
   parameter int ORDER_DEPTH  = 8,
   parameter int DESC_DEPTH   = 4,
   parameter int BYPASS_DEPTH = 64,
   parameter int BYPASS_EN    = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         s_data_tdata,
   input  logic [KEEP_WIDTH-1:0]         s_data_tkeep,
   input  logic                          s_data_tvalid,
   output logic                          s_data_tready,
   input  logic                          s_data_tlast,
   output logic [DATA_WIDTH-1:0]         m_data_tdata,
   output logic [KEEP_WIDTH-1:0]         m_data_tkeep,
   output logic                          m_data_tvalid,
   input  logic                          m_data_tready,
   output logic                          m_data_tlast,
   output logic [DESC_WIDTH-1:0]         m_desc_tdata,
   output logic                          m_desc_tvalid,
   input  logic                          m_desc_tready,
   output logic [LANES*DATA_WIDTH-1:0]   m_eng_tdata,
   output logic [LANES*KEEP_WIDTH-1:0]   m_eng_tkeep,
   output logic [LANES-1:0]              m_eng_tvalid,
   input  logic [LANES-1:0]              m_eng_tready,
   output logic [LANES-1:0]              m_eng_tlast,
   input  logic [LANES*RES_WIDTH-1:0]    s_res_tdata,
   input  logic [LANES-1:0]              s_res_tvalid,
   output logic [LANES-1:0]              s_res_tready,
   output logic [RES_WIDTH-1:0]          m_res_tdata,
   output logic                          m_res_tvalid,
   input  logic                          m_res_tready,
   output logic [$clog2(ORDER_DEPTH):0]  inflight
);

   localparam int LANE_W = `PANIC_LANE_W(LANES);
   localparam int BYP_W  = DATA_WIDTH + KEEP_WIDTH + 1;
   localparam int CNT_W  = $clog2(ORDER_DEPTH) + 1;

   state_t            state_q, state_d;
   logic [LANE_W-1:0] lane_ptr_q, lane_ptr_d, lane_next;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic              desc_push, desc_rdy;
   logic              ord_push, ord_rdy, ord_pop, ord_valid;
   logic [LANE_W-1:0] ord_head;
   logic              byp_push, byp_rdy, byp_ok, pad;

   assign lane_next = (lane_ptr_q == LANE_W'(LANES - 1)) ? '0 : lane_ptr_q + 1'b1;
   assign byp_ok    = (BYPASS_EN == 0) || byp_rdy;
   assign pad       = (state_q == ST_PAD);

   // Reset gates every ready/valid so nothing handshakes while rst is held.
   always_comb begin
      state_d       = state_q;
      lane_ptr_d    = lane_ptr_q;
      s_data_tready = 1'b0;
      m_eng_tvalid  = '0;
      desc_push     = 1'b0;
      ord_push      = 1'b0;
      byp_push      = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_DESC: begin
               s_data_tready = desc_rdy && ord_rdy;
               if (s_data_tvalid && s_data_tready) begin
                  desc_push = 1'b1;
                  ord_push  = 1'b1;
                  state_d   = s_data_tlast ? ST_PAD : ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               s_data_tready            = m_eng_tready[lane_ptr_q] && byp_ok;
               m_eng_tvalid[lane_ptr_q] = s_data_tvalid && byp_ok;
               if (s_data_tvalid && s_data_tready) begin
                  byp_push = (BYPASS_EN != 0);
                  if (s_data_tlast) begin
                     lane_ptr_d = lane_next;
                     state_d    = ST_DESC;
                  end
               end
            end
            ST_PAD: begin
               m_eng_tvalid[lane_ptr_q] = 1'b1;
               if (m_eng_tready[lane_ptr_q]) begin
                  lane_ptr_d = lane_next;
                  state_d    = ST_DESC;
               end
            end
            default: state_d = ST_DESC;
         endcase
      end
   end

   always_comb begin
      inflight_d = inflight_q + CNT_W'(ord_push) - CNT_W'(ord_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_DESC;
         lane_ptr_q <= '0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         lane_ptr_q <= lane_ptr_d;
         inflight_q <= inflight_d;
      end
   end

   assign inflight = inflight_q;

   // Every lane sees the same beat; only the selected lane's valid is raised.
   assign m_eng_tdata = pad ? '0 : {LANES{s_data_tdata}};
   assign m_eng_tkeep = pad ? '0 : {LANES{s_data_tkeep}};
   assign m_eng_tlast = pad ? '1 : {LANES{s_data_tlast}};

   assign m_res_tvalid = ord_valid && s_res_tvalid[ord_head];
   assign m_res_tdata  = s_res_tdata[ord_head*RES_WIDTH +: RES_WIDTH];
   assign ord_pop      = m_res_tvalid && m_res_tready;

   always_comb begin
      s_res_tready           = '0;
      s_res_tready[ord_head] = ord_valid && m_res_tready;
   end

   panic_sync_fifo #(.WIDTH(DESC_WIDTH), .DEPTH(DESC_DEPTH)) u_desc_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_data   (s_data_tdata[DESC_WIDTH-1:0]),
      .in_valid  (desc_push),
      .in_ready  (desc_rdy),
      .out_data  (m_desc_tdata),
      .out_valid (m_desc_tvalid),
      .out_ready (m_desc_tready)
   );

   panic_sync_fifo #(.WIDTH(LANE_W), .DEPTH(ORDER_DEPTH)) u_order_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_data   (lane_ptr_q),
      .in_valid  (ord_push),
      .in_ready  (ord_rdy),
      .out_data  (ord_head),
      .out_valid (ord_valid),
      .out_ready (ord_pop)
   );

   generate
      if (BYPASS_EN != 0) begin : g_bypass
         logic [BYP_W-1:0] byp_out;
         panic_sync_fifo #(.WIDTH(BYP_W), .DEPTH(BYPASS_DEPTH)) u_byp_fifo (
            .clk       (clk),
            .rst       (rst),
            .in_data   ({s_data_tdata, s_data_tkeep, s_data_tlast}),
            .in_valid  (byp_push),
            .in_ready  (byp_rdy),
            .out_data  (byp_out),
            .out_valid (m_data_tvalid),
            .out_ready (m_data_tready)
         );
         assign {m_data_tdata, m_data_tkeep, m_data_tlast} = byp_out;
      end else begin : g_no_bypass
         assign m_data_tdata  = '0;
         assign m_data_tkeep  = '0;
         assign m_data_tlast  = 1'b0;
         assign m_data_tvalid = 1'b0;
         assign byp_rdy       = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire
